// File: rtl/ctrl_seq.sv
// ctrl_seq: multi-cycle control sequencer for the 4-bit accumulator computer.
// Owns the program counter and steps FETCH -> DECODE -> EXEC for each instruction,
// decoding the IR opcode into register load enables and datapath mux/ALU controls.
//
// Ports:
//   clk      in   system clock, all state changes on posedge
//   clr      in   asynchronous active-low reset (state=IDLE, pc=0)
//   start    in   begins execution from pc=0 when in IDLE or HALT
//   ir       in   IR register output; opcode ir[7:4], operand ir[3:0]
//   a_zero   in   accumulator == 0 flag from datapath
//   pc       out  instruction memory address (registered)
//   ld_ir    out  IR load enable (FETCH only)
//   ld_a     out  accumulator load enable
//   ld_out   out  OUT register load enable
//   a_sel    out  accumulator input mux: 0 = immediate, 1 = ALU result
//   alu_sub  out  ALU op: 0 = A+imm, 1 = A-imm
//   imm      out  ir[3:0]
//   halted   out  high in HALT
//   busy     out  high in FETCH, DECODE, EXEC
module ctrl_seq #(
    parameter int PCW = 4,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           start,
    input  logic [7:0]     ir,
    input  logic           a_zero,
    output logic [PCW-1:0] pc,
    output logic           ld_ir,
    output logic           ld_a,
    output logic           ld_out,
    output logic           a_sel,
    output logic           alu_sub,
    output logic [3:0]     imm,
    output logic           halted,
    output logic           busy
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StHalt
    } state_t;

    localparam logic [OPW-1:0] OpLdi = OPW'(1);
    localparam logic [OPW-1:0] OpAdd = OPW'(2);
    localparam logic [OPW-1:0] OpSub = OPW'(3);
    localparam logic [OPW-1:0] OpOut = OPW'(4);
    localparam logic [OPW-1:0] OpJmp = OPW'(5);
    localparam logic [OPW-1:0] OpJz  = OPW'(6);
    localparam logic [OPW-1:0] OpHlt = OPW'(15);

    state_t         state_q, state_d;
    logic [PCW-1:0] pc_q, pc_d;
    logic [OPW-1:0] opcode;
    logic [PCW-1:0] target;

    assign opcode = ir[7 -: OPW];
    assign target = PCW'(ir[3:0]);
    assign imm    = ir[3:0];
    assign pc     = pc_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= StIdle;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Enables decode purely from state, so the asynchronous return to IDLE
    // drops every enable the moment clr falls.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ld_ir   = 1'b0;
        ld_a    = 1'b0;
        ld_out  = 1'b0;
        a_sel   = 1'b0;
        alu_sub = 1'b0;
        halted  = 1'b0;
        busy    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFetch;
                    pc_d    = '0;
                end
            end
            StFetch: begin
                busy    = 1'b1;
                ld_ir   = 1'b1;
                pc_d    = pc_q + PCW'(1);
                state_d = StDecode;
            end
            StDecode: begin
                busy    = 1'b1;
                state_d = (opcode == OpHlt) ? StHalt : StExec;
            end
            StExec: begin
                busy    = 1'b1;
                state_d = StFetch;
                case (opcode)
                    OpLdi: ld_a = 1'b1;
                    OpAdd: begin
                        ld_a  = 1'b1;
                        a_sel = 1'b1;
                    end
                    OpSub: begin
                        ld_a    = 1'b1;
                        a_sel   = 1'b1;
                        alu_sub = 1'b1;
                    end
                    OpOut: ld_out = 1'b1;
                    OpJmp: pc_d = target;
                    OpJz: begin
                        if (a_zero) pc_d = target;
                    end
                    default: ;  // NOP and unused opcodes
                endcase
            end
            StHalt: begin
                halted = 1'b1;
                if (start) begin
                    state_d = StFetch;
                    pc_d    = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed bench for ctrl_seq. A small instruction memory and IR register model
// surround the DUT; each expected output vector is pushed to a scoreboard when
// the step is driven and popped/compared when the DUT output is sampled.
module tb_ctrl_seq;

    logic       clk;
    logic       clr;
    logic       start;
    logic [7:0] ir;
    logic       a_zero;
    logic [3:0] pc;
    logic       ld_ir, ld_a, ld_out, a_sel, alu_sub, halted, busy;
    logic [3:0] imm;

    logic [7:0] mem [16];

    int n_asrt = 0;
    int n_fail = 0;

    typedef struct {
        string       tag;
        logic [14:0] exp;
    } item_t;

    item_t sb[$];

    logic [14:0] obs;
    assign obs = {pc, ld_ir, ld_a, ld_out, a_sel, alu_sub, halted, busy, imm};

    ctrl_seq #(.PCW(4), .OPW(4)) dut (
        .clk    (clk),
        .clr    (clr),
        .start  (start),
        .ir     (ir),
        .a_zero (a_zero),
        .pc     (pc),
        .ld_ir  (ld_ir),
        .ld_a   (ld_a),
        .ld_out (ld_out),
        .a_sel  (a_sel),
        .alu_sub(alu_sub),
        .imm    (imm),
        .halted (halted),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // IR register of the surrounding datapath.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) ir <= 8'h00;
        else if (ld_ir) ir <= mem[pc];
    end

    // en = {ld_ir, ld_a, ld_out}
    function automatic logic [14:0] ex(input logic [3:0] p, input logic [2:0] en,
                                       input logic as, input logic sub, input logic h,
                                       input logic b, input logic [3:0] im);
        return {p, en, as, sub, h, b, im};
    endfunction

    task automatic chk(input string tag, input logic [14:0] exp, input bit at_edge);
        item_t it;
        sb.push_back('{tag: tag, exp: exp});
        if (at_edge) @(negedge clk);
        else #1;
        it = sb.pop_front();
        n_asrt++;
        assert (obs === it.exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", it.tag, obs, it.exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [14:0] exp);
        chk(tag, exp, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish within bound");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        clr    = 1'b0;
        start  = 1'b0;
        a_zero = 1'b0;

        // Reset and idle
        cyc("rst", ex(4'd0, 3'b000, 0, 0, 0, 0, 4'h0));
        clr = 1'b1;
        for (int i = 0; i < 5; i++) cyc("idle", ex(4'd0, 3'b000, 0, 0, 0, 0, 4'h0));

        // LDI 7, then HLT; start pulse in DECODE must be ignored
        mem[0] = 8'h17;
        mem[1] = 8'hF0;
        start  = 1'b1;
        cyc("ldi_fetch", ex(4'd0, 3'b100, 0, 0, 0, 1, 4'h0));
        start = 1'b0;
        cyc("ldi_dec", ex(4'd1, 3'b000, 0, 0, 0, 1, 4'h7));
        start = 1'b1;
        cyc("ldi_exec", ex(4'd1, 3'b010, 0, 0, 0, 1, 4'h7));
        start = 1'b0;
        cyc("hlt_fetch", ex(4'd1, 3'b100, 0, 0, 0, 1, 4'h7));
        cyc("hlt_dec", ex(4'd2, 3'b000, 0, 0, 0, 1, 4'h0));
        for (int i = 0; i < 10; i++) cyc("halt", ex(4'd2, 3'b000, 0, 0, 1, 0, 4'h0));

        // LDI 3; SUB 3; JZ 9 (taken); JMP 15; NOP@15 wraps; rerun with JZ not taken; HLT
        mem[0]  = 8'h13;
        mem[1]  = 8'h33;
        mem[2]  = 8'h69;
        mem[3]  = 8'hF0;
        mem[9]  = 8'h5F;
        mem[15] = 8'h00;
        start   = 1'b1;
        cyc("restart", ex(4'd0, 3'b100, 0, 0, 0, 1, 4'h0));
        start = 1'b0;
        cyc("ldi3_dec", ex(4'd1, 3'b000, 0, 0, 0, 1, 4'h3));
        cyc("ldi3_exec", ex(4'd1, 3'b010, 0, 0, 0, 1, 4'h3));
        cyc("sub_fetch", ex(4'd1, 3'b100, 0, 0, 0, 1, 4'h3));
        cyc("sub_dec", ex(4'd2, 3'b000, 0, 0, 0, 1, 4'h3));
        cyc("sub_exec", ex(4'd2, 3'b010, 1, 1, 0, 1, 4'h3));
        cyc("jz_fetch", ex(4'd2, 3'b100, 0, 0, 0, 1, 4'h3));
        a_zero = 1'b1;
        cyc("jz_dec", ex(4'd3, 3'b000, 0, 0, 0, 1, 4'h9));
        cyc("jz_exec", ex(4'd3, 3'b000, 0, 0, 0, 1, 4'h9));
        cyc("jz_taken", ex(4'd9, 3'b100, 0, 0, 0, 1, 4'h9));
        a_zero = 1'b0;
        cyc("jmp_dec", ex(4'd10, 3'b000, 0, 0, 0, 1, 4'hF));
        cyc("jmp_exec", ex(4'd10, 3'b000, 0, 0, 0, 1, 4'hF));
        cyc("fetch15", ex(4'd15, 3'b100, 0, 0, 0, 1, 4'hF));
        cyc("wrap_dec", ex(4'd0, 3'b000, 0, 0, 0, 1, 4'h0));
        cyc("nop_exec", ex(4'd0, 3'b000, 0, 0, 0, 1, 4'h0));
        cyc("re_fetch0", ex(4'd0, 3'b100, 0, 0, 0, 1, 4'h0));
        cyc("re_ldi_dec", ex(4'd1, 3'b000, 0, 0, 0, 1, 4'h3));
        cyc("re_ldi_exec", ex(4'd1, 3'b010, 0, 0, 0, 1, 4'h3));
        cyc("re_sub_fetch", ex(4'd1, 3'b100, 0, 0, 0, 1, 4'h3));
        cyc("re_sub_dec", ex(4'd2, 3'b000, 0, 0, 0, 1, 4'h3));
        cyc("re_sub_exec", ex(4'd2, 3'b010, 1, 1, 0, 1, 4'h3));
        cyc("re_jz_fetch", ex(4'd2, 3'b100, 0, 0, 0, 1, 4'h3));
        cyc("re_jz_dec", ex(4'd3, 3'b000, 0, 0, 0, 1, 4'h9));
        cyc("re_jz_exec", ex(4'd3, 3'b000, 0, 0, 0, 1, 4'h9));
        cyc("jz_not_taken", ex(4'd3, 3'b100, 0, 0, 0, 1, 4'h9));
        cyc("hlt2_dec", ex(4'd4, 3'b000, 0, 0, 0, 1, 4'h0));
        cyc("halt2", ex(4'd4, 3'b000, 0, 0, 1, 0, 4'h0));

        // ADD 1, aborted by clr during EXEC
        mem[0] = 8'h21;
        start  = 1'b1;
        cyc("add_fetch", ex(4'd0, 3'b100, 0, 0, 0, 1, 4'h0));
        start = 1'b0;
        cyc("add_dec", ex(4'd1, 3'b000, 0, 0, 0, 1, 4'h1));
        cyc("add_exec", ex(4'd1, 3'b010, 1, 0, 0, 1, 4'h1));
        clr = 1'b0;
        chk("clr_async", ex(4'd0, 3'b000, 0, 0, 0, 0, 4'h0), 1'b0);
        start = 1'b1;
        cyc("clr_held", ex(4'd0, 3'b000, 0, 0, 0, 0, 4'h0));
        start = 1'b0;
        clr   = 1'b1;
        cyc("post_clr", ex(4'd0, 3'b000, 0, 0, 0, 0, 4'h0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/ctrl_seq.md
Name: ctrl_seq

Overview:
- Multi-cycle control sequencer for the 4-bit accumulator computer.
- Owns the 4-bit program counter and steps a FETCH/DECODE/EXEC cycle.
- Drives the load enables (L) of the downstream n=4/n=8 register instances: IR, accumulator A and OUT.
- Consumes the IR register output and the accumulator zero flag; emits ALU and mux controls to the datapath.

Parameters:
- PCW, 4, program counter / instruction address width.
- OPW, 4, opcode width (ir[7:4]); operand width is fixed at 4 (ir[3:0]).

Ports:
- clk  input  1  system clock; all state changes on posedge.
- clr  input  1  asynchronous, active-low reset; clears state and pc immediately.
- start  input  1  in IDLE or HALT, begins execution from pc=0.
- ir  input  8  IR register output; opcode ir[7:4], operand ir[3:0].
- a_zero  input  1  accumulator == 0, from datapath.
- pc  output  PCW  instruction memory address (registered).
- ld_ir  output  1  load enable to IR register.
- ld_a  output  1  load enable to accumulator A.
- ld_out  output  1  load enable to OUT register.
- a_sel  output  1  A input mux: 0 = ir[3:0] immediate, 1 = ALU result.
- alu_sub  output  1  ALU op: 0 = A+imm, 1 = A-imm (4-bit, wrap, no carry out).
- imm  output  4  equals ir[3:0] at all times.
- halted  output  1  high in HALT state.
- busy  output  1  high in FETCH, DECODE and EXEC.

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, HALT.
- Reset (clr=0, asynchronous): state=IDLE, pc=0. All enables, a_sel, alu_sub, halted and busy are 0.
- Outputs other than pc are decoded combinationally from state and ir. pc is a register.
- IDLE:
  - start=1 -> FETCH with pc=0.
  - Otherwise hold.
- FETCH:
  - ld_ir=1 for exactly this cycle, so IR captures mem[pc] at the clock edge.
  - pc <= pc+1, mod 16; 15 wraps to 0.
  - -> DECODE.
- DECODE:
  - No enables asserted; ir is now stable.
  - Opcode F -> HALT.
  - Any other opcode -> EXEC.
- EXEC, by opcode, each for one cycle, then -> FETCH:
  - 0 NOP: no enables.
  - 1 LDI: ld_a=1, a_sel=0.
  - 2 ADD: ld_a=1, a_sel=1, alu_sub=0.
  - 3 SUB: ld_a=1, a_sel=1, alu_sub=1.
  - 4 OUT: ld_out=1.
  - 5 JMP: pc <= ir[3:0].
  - 6 JZ: if a_zero=1, pc <= ir[3:0]; else pc unchanged.
  - Opcodes 7-E: treated as NOP.
- Instruction latency: 3 clocks (FETCH, DECODE, EXEC). HLT takes 2 clocks to reach HALT.
- HALT:
  - halted=1, no enables, pc frozen.
  - start=1 -> FETCH with pc=0 (restart).
- start is ignored while busy=1.
- At most one of ld_ir, ld_a, ld_out is high in any cycle.
- Reset asserted mid-instruction aborts at once: no enable may be high while clr=0.
- Reset deassertion takes effect at the first posedge after clr returns high.
- JMP/JZ target 15 followed by the normal increment wraps pc to 0. No overflow flag.

Test Plan:
- Reset, hold start=0 for 5 clks -> state IDLE, pc=0, all enables 0, busy=0, halted=0.
- start pulse, ir=0x17 presented after FETCH -> ld_ir high in cycle 1 only; pc=1 after cycle 1; cycle 3 has ld_a=1, a_sel=0, imm=7; back in FETCH at cycle 4.
- Program LDI 3; SUB 3; JZ 9 with a_zero driven 1 on the JZ -> pc=9 after its EXEC. Rerun with a_zero=0 -> pc=3 after its EXEC.
- JMP 15 then NOP at address 15 -> pc sequence 15 then wraps to 0 after the FETCH of address 15.
- ir=0xF0 -> HALT after DECODE; halted=1, pc frozen for 10 clks, no enables. start=1 -> FETCH with pc=0, halted=0.
- clr driven low mid-EXEC of an ADD -> ld_a drops within the same cycle with no clock edge needed; state IDLE, pc=0. start is ignored while busy, checked with a pulse during DECODE.
